bcd_cout_apb_reader: RTL and testbench

- Downstream end of the decade-counter interface. Consumes the counter's BCD units value and carry-out pulse, and keeps a multi-digit BCD tally of carries.
- Makes the full count readable by software through an 8-bit APB slave with snapshot-consistent reads.
- Sits between the decade counter and the peripheral APB bus. It is the reader for the counter's writer side.

---
 rtl/bcd_cout_apb_reader.sv | 148 ++++++++++++++
 tb/tb_bcd_cout_apb_reader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_cout_apb_reader.sv
// rtl/bcd_cout_apb_reader.sv - BCD carry tally behind an 8-bit APB slave with coherent snapshot reads
module bcd_cout_apb_reader #(
  parameter int APB_ADDR_WIDTH = 8,
  parameter int APB_DATA_WIDTH = 8,
  parameter int NUM_DIGITS     = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [3:0]                cnt_in,
  input  logic                      cout_in,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [APB_DATA_WIDTH-1:0] pwdata,
  output logic [APB_DATA_WIDTH-1:0] prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic                      ovf_irq
);

  // Units digit plus NUM_DIGITS tally digits, packed two per SNAP byte.
  localparam int NBYTES = (NUM_DIGITS + 2) / 2;
  localparam int NVIEW  = 2 * NBYTES;
  localparam logic [2:0] LAST_OFF = 3'(1 + NBYTES);

  logic                       cout_q;
  logic                       en_q, en_d;
  logic                       irq_en_q, irq_en_d;
  logic                       ovf_q, ovf_d;
  logic [NUM_DIGITS-1:0][3:0] tally_q, tally_d;
  logic [NUM_DIGITS-1:0][3:0] shadow_q, shadow_d;

  logic [NUM_DIGITS-1:0][3:0] inc_val;
  logic                       wrap;
  logic [NVIEW-1:0][3:0]      snap_view;
  logic [7:0]                 rdata;
  logic [2:0]                 off;
  logic                       hit, access, wr_en, rd_en;
  logic                       carry_ev, clr, ovf_set;
  logic                       unused_pwdata;

  assign off      = paddr[2:0];
  assign hit      = ((paddr >> 3) == '0) && (off <= LAST_OFF);
  assign access   = psel & penable;
  assign wr_en    = access & pwrite & hit;
  assign rd_en    = access & ~pwrite & hit;
  assign carry_ev = cout_in & ~cout_q;
  assign clr      = wr_en && (off == 3'd0) && pwdata[1];
  assign ovf_set  = carry_ev && en_q && !clr && wrap;

  assign pready        = 1'b1;
  assign pslverr       = access & ~hit;
  assign ovf_irq       = ovf_q & irq_en_q;
  assign unused_pwdata = ^pwdata[APB_DATA_WIDTH-1:3];

  // Full-ripple BCD increment of the tally; wrap flags the all-nines rollover.
  always_comb begin : inc_blk
    logic c;
    inc_val = tally_q;
    c       = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (tally_q[i] == 4'd9) begin
          inc_val[i] = 4'd0;
        end else begin
          inc_val[i] = tally_q[i] + 4'd1;
          c          = 1'b0;
        end
      end
    end
    wrap = c;
  end

  // Next state: CLR beats a same-cycle carry, overflow set beats W1C, shadow takes pre-increment tally.
  always_comb begin
    en_d     = en_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    tally_d  = tally_q;
    shadow_d = shadow_q;
    if (wr_en && (off == 3'd0)) begin
      en_d     = pwdata[0];
      irq_en_d = pwdata[2];
    end
    if (clr) begin
      tally_d = '0;
    end else if (carry_ev && en_q) begin
      tally_d = inc_val;
    end
    if (wr_en && (off == 3'd1) && pwdata[0]) begin
      ovf_d = 1'b0;
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
    if (rd_en && (off == 3'd2)) begin
      shadow_d = tally_q;
    end
  end

  // Read view: byte 0x2 is live, higher bytes come from the shadow captured by the 0x2 read.
  always_comb begin
    snap_view    = '0;
    snap_view[0] = cnt_in;
    for (int i = 1; i <= NUM_DIGITS; i++) begin
      snap_view[i] = shadow_q[i-1];
    end
    snap_view[1] = tally_q[0];
  end

  // Register read mux; data only driven during a mapped access phase.
  always_comb begin
    rdata = 8'h00;
    case (off)
      3'd0:    rdata = {5'b0, irq_en_q, 1'b0, en_q};
      3'd1:    rdata = {7'b0, ovf_q};
      default: begin
        for (int k = 0; k < NBYTES; k++) begin
          if (off == 3'(k + 2)) begin
            rdata = {snap_view[2*k+1], snap_view[2*k]};
          end
        end
      end
    endcase
    prdata = (access && hit) ? APB_DATA_WIDTH'(rdata) : '0;
  end

  // State registers; edge detector runs regardless of EN.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cout_q   <= 1'b0;
      en_q     <= 1'b1;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      tally_q  <= '0;
      shadow_q <= '0;
    end else begin
      cout_q   <= cout_in;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      tally_q  <= tally_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: tb/tb_bcd_cout_apb_reader.sv
// tb/tb_bcd_cout_apb_reader.sv - directed self-checking bench for bcd_cout_apb_reader
module tb_bcd_cout_apb_reader;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] cnt_in;
  logic       cout_in;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata;
  logic       pready, pslverr, ovf_irq;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0] d;
  logic       e;

  always #5 clk = ~clk;

  bcd_cout_apb_reader #(.APB_ADDR_WIDTH(8), .APB_DATA_WIDTH(8), .NUM_DIGITS(4)) dut (
    .clk(clk), .rstn(rstn), .cnt_in(cnt_in), .cout_in(cout_in),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .ovf_irq(ovf_irq)
  );

  task automatic apb_read(input logic [7:0] addr, output logic [7:0] data, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    data = prdata; err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_write(input logic [7:0] addr, input logic [7:0] wdata, input bit with_carry,
                           output logic err, output logic [7:0] rd);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    if (with_carry) cout_in = 1'b1;
    #1;
    err = pslverr; rd = prdata;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; cout_in = 1'b0;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 cout_in = 1'b1;
      @(posedge clk); #1 cout_in = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [7:0] addrs [5];
    logic [7:0] exps  [5];
    addrs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    exps  = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    rstn = 1'b0; cnt_in = 4'd0; cout_in = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 cout_in = ~cout_in;
    end
    #1;
    vectors++; if (pready !== 1'b1) begin miscompares++; $display("FAIL rst_pready got %b want 1", pready); end
    vectors++; if (ovf_irq !== 1'b0) begin miscompares++; $display("FAIL rst_irq got %b want 0", ovf_irq); end
    vectors++; if (prdata !== 8'h00) begin miscompares++; $display("FAIL rst_prdata got %h want 00", prdata); end
    vectors++; if (pslverr !== 1'b0) begin miscompares++; $display("FAIL rst_pslverr got %b want 0", pslverr); end
    cout_in = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apb_read(addrs[i], d, e);
      vectors++;
      if (d !== exps[i]) begin miscompares++; $display("FAIL rst_read addr=%h got %h want %h", addrs[i], d, exps[i]); end
    end
  endtask

  task automatic test_carry_count();
    cnt_in = 4'd7;
    pulse(23);
    apb_read(8'h02, d, e);
    vectors++; if (d !== 8'h37) begin miscompares++; $display("FAIL cnt23_b0 got %h want 37", d); end
    apb_read(8'h03, d, e);
    vectors++; if (d !== 8'h02) begin miscompares++; $display("FAIL cnt23_b1 got %h want 02", d); end
    @(posedge clk); #1 cout_in = 1'b1;
    repeat (5) @(posedge clk);
    #1 cout_in = 1'b0;
    apb_read(8'h02, d, e);
    vectors++; if (d !== 8'h47) begin miscompares++; $display("FAIL hold_b0 got %h want 47", d); end
    apb_read(8'h03, d, e);
    vectors++; if (d !== 8'h02) begin miscompares++; $display("FAIL hold_b1 got %h want 02", d); end
  endtask

  task automatic test_snapshot();
    cnt_in = 4'd5;
    apb_write(8'h00, 8'h03, 1'b0, e, d);
    pulse(199);
    apb_read(8'h02, d, e);
    vectors++; if (d !== 8'h95) begin miscompares++; $display("FAIL snap_b0 got %h want 95", d); end
    pulse(1);
    apb_read(8'h03, d, e);
    vectors++; if (d !== 8'h19) begin miscompares++; $display("FAIL snap_b1 got %h want 19", d); end
    apb_read(8'h04, d, e);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL snap_b2 got %h want 00", d); end
    apb_read(8'h02, d, e);
    vectors++; if (d !== 8'h05) begin miscompares++; $display("FAIL fresh_b0 got %h want 05", d); end
    apb_read(8'h03, d, e);
    vectors++; if (d !== 8'h20) begin miscompares++; $display("FAIL fresh_b1 got %h want 20", d); end
  endtask

  task automatic test_conflicts();
    apb_write(8'h00, 8'h03, 1'b1, e, d);
    apb_read(8'h02, d, e);
    vectors++; if (d !== 8'h05) begin miscompares++; $display("FAIL clr_carry_b0 got %h want 05", d); end
    apb_read(8'h03, d, e);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL clr_carry_b1 got %h want 00", d); end
    pulse(2);
    apb_write(8'h00, 8'h00, 1'b0, e, d);
    pulse(3);
    apb_read(8'h02, d, e);
    vectors++; if (d !== 8'h25) begin miscompares++; $display("FAIL en0_b0 got %h want 25", d); end
    apb_read(8'h00, d, e);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL en0_ctrl got %h want 00", d); end
    apb_write(8'h00, 8'h01, 1'b0, e, d);
    pulse(1);
    apb_read(8'h02, d, e);
    vectors++; if (d !== 8'h35) begin miscompares++; $display("FAIL en1_b0 got %h want 35", d); end
  endtask

  task automatic test_overflow();
    apb_write(8'h00, 8'h03, 1'b0, e, d);
    pulse(9999);
    apb_read(8'h02, d, e);
    vectors++; if (d !== 8'h95) begin miscompares++; $display("FAIL n9999_b0 got %h want 95", d); end
    apb_read(8'h03, d, e);
    vectors++; if (d !== 8'h99) begin miscompares++; $display("FAIL n9999_b1 got %h want 99", d); end
    apb_read(8'h04, d, e);
    vectors++; if (d !== 8'h09) begin miscompares++; $display("FAIL n9999_b2 got %h want 09", d); end
    apb_read(8'h01, d, e);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL n9999_status got %h want 00", d); end
    pulse(1);
    apb_read(8'h02, d, e);
    vectors++; if (d !== 8'h05) begin miscompares++; $display("FAIL wrap_b0 got %h want 05", d); end
    apb_read(8'h03, d, e);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL wrap_b1 got %h want 00", d); end
    apb_read(8'h04, d, e);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL wrap_b2 got %h want 00", d); end
    apb_read(8'h01, d, e);
    vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL wrap_status got %h want 01", d); end
    vectors++; if (ovf_irq !== 1'b0) begin miscompares++; $display("FAIL irq_masked got %b want 0", ovf_irq); end
    apb_write(8'h00, 8'h05, 1'b0, e, d);
    #1;
    vectors++; if (ovf_irq !== 1'b1) begin miscompares++; $display("FAIL irq_on got %b want 1", ovf_irq); end
    apb_read(8'h00, d, e);
    vectors++; if (d !== 8'h05) begin miscompares++; $display("FAIL ctrl_irqen got %h want 05", d); end
    apb_write(8'h01, 8'h01, 1'b0, e, d);
    apb_read(8'h01, d, e);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL w1c_status got %h want 00", d); end
    vectors++; if (ovf_irq !== 1'b0) begin miscompares++; $display("FAIL w1c_irq got %b want 0", ovf_irq); end
  endtask

  task automatic test_ovf_w1c_conflict();
    pulse(9999);
    apb_read(8'h01, d, e);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL pre_conf_status got %h want 00", d); end
    apb_write(8'h01, 8'h01, 1'b1, e, d);
    apb_read(8'h01, d, e);
    vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL conf_status got %h want 01", d); end
    vectors++; if (ovf_irq !== 1'b1) begin miscompares++; $display("FAIL conf_irq got %b want 1", ovf_irq); end
    apb_read(8'h02, d, e);
    vectors++; if (d !== 8'h05) begin miscompares++; $display("FAIL conf_b0 got %h want 05", d); end
  endtask

  task automatic test_bus_errors();
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00;
    #1;
    vectors++; if (prdata !== 8'h00) begin miscompares++; $display("FAIL setup_prdata got %h want 00", prdata); end
    vectors++; if (pslverr !== 1'b0) begin miscompares++; $display("FAIL setup_pslverr got %b want 0", pslverr); end
    @(posedge clk); #1 psel = 1'b0;
    apb_read(8'h07, d, e);
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL err7_pslverr got %b want 1", e); end
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL err7_prdata got %h want 00", d); end
    apb_read(8'h12, d, e);
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL err12_pslverr got %b want 1", e); end
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL err12_prdata got %h want 00", d); end
    apb_read(8'h05, d, e);
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL err5_pslverr got %b want 1", e); end
    apb_read(8'h04, d, e);
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL last_snap_pslverr got %b want 0", e); end
    apb_write(8'h10, 8'h00, 1'b0, e, d);
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL wr10_pslverr got %b want 1", e); end
    apb_write(8'h11, 8'h01, 1'b0, e, d);
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL wr11_pslverr got %b want 1", e); end
    apb_write(8'h07, 8'hFF, 1'b0, e, d);
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL wr7_pslverr got %b want 1", e); end
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL wr7_prdata got %h want 00", d); end
    apb_read(8'h00, d, e);
    vectors++; if (d !== 8'h05) begin miscompares++; $display("FAIL err_ctrl_kept got %h want 05", d); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL ctrl_pslverr got %b want 0", e); end
    apb_read(8'h01, d, e);
    vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL err_status_kept got %h want 01", d); end
    apb_write(8'h02, 8'hAA, 1'b0, e, d);
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL wr_snap_pslverr got %b want 0", e); end
    apb_read(8'h02, d, e);
    vectors++; if (d !== 8'h05) begin miscompares++; $display("FAIL wr_snap_kept got %h want 05", d); end
  endtask

  initial begin
    test_reset();
    test_carry_count();
    test_snapshot();
    test_conflicts();
    test_overflow();
    test_ovf_w1c_conflict();
    test_bus_errors();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
